stream_fifo: RTL and testbench

//   Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.

---
 rtl/stream_fifo.sv | 109 ++++++++++
 tb/tb_stream_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : First-word-fall-through FIFO with valid/ready handshakes on
//               both sides, synchronous flush, occupancy count and
//               almost-full / almost-empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [CW-1:0]     C_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0]     C_EMPTY   = '0;
    localparam logic [CW-1:0]     C_AFULL   = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0]     C_AEMPTY  = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0]     C_CNT_ONE = CW'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

    // Storage is deliberately not reset; validity is tracked by count_q.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    logic w_push;
    logic w_pop;

    // Handshake flags depend on registered count only, so there is no
    // combinational path from s_valid to s_ready or from m_ready to m_valid.
    assign s_ready      = (count_q != C_FULL);
    assign m_valid      = (count_q != C_EMPTY);
    assign count        = count_q;
    assign almost_full  = (count_q >= C_AFULL);
    assign almost_empty = (count_q <= C_AEMPTY);

    // Head word is masked to zero while empty so stale memory never shows.
    assign m_data = m_valid ? mem_q[rd_ptr_q] : '0;

    // A flush cancels any handshake that happens in the same cycle.
    assign w_push = s_valid & s_ready & ~flush;
    assign w_pop  = m_valid & m_ready & ~flush;

    // Next-state for pointers and occupancy; push+pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + C_CNT_ONE;
            end else if (w_pop && !w_push) begin
                count_d = count_q - C_CNT_ONE;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage write port; accepted words land at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_fifo
// Description : Self-checking bench for stream_fifo: directed vector table,
//               hand-written corner sequences and a randomised run checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;

    int total;
    int bad;

    // Reference model: contents of the FIFO, head at index 0.
    logic [DW-1:0] model_q[$];
    logic          last_push;

    stream_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (12),
        .AEMPTY_LEVEL(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        int  n;
        bit  do_push;
        bit  do_pop;
        n = model_q.size();
        last_push = 1'b0;
        if (flush) begin
            model_q.delete();
        end else begin
            do_push = s_valid && (n < DEPTH);
            do_pop  = m_ready && (n > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(s_data);
            last_push = do_push;
        end
    endtask

    task automatic check_model();
        int n;
        n = model_q.size();
        chk("m_count",   32'(count),        32'(n));
        chk("m_s_ready", 32'(s_ready),      32'(n != DEPTH));
        chk("m_m_valid", 32'(m_valid),      32'(n != 0));
        chk("m_m_data",  32'(m_data),       (n != 0) ? 32'(model_q[0]) : 32'h0);
        chk("m_afull",   32'(almost_full),  32'(n >= 12));
        chk("m_aempty",  32'(almost_empty), 32'(n <= 2));
    endtask

    // Called at a negedge: drive inputs, take one edge, land on next negedge.
    task automatic step(input logic f, input logic sv, input logic [DW-1:0] sd, input logic mr);
        flush   = f;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic          f;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic [CW-1:0] ecount;
        logic          emv;
        logic [DW-1:0] emd;
        logic          esr;
        logic          eae;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [DW-1:0] sent[45];
        logic          hold;
        int            npush;

        total = 0;
        bad   = 0;

        tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h44, 1'b1, 5'd2, 1'b1, 8'h33, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 8'h55, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8'h66, 1'b1, 5'd1, 1'b1, 8'h66, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        last_push = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_count",  32'(count),        32'd0);
        chk("rst_sready", 32'(s_ready),      32'd1);
        chk("rst_mvalid", 32'(m_valid),      32'd0);
        chk("rst_mdata",  32'(m_data),       32'd0);
        chk("rst_afull",  32'(almost_full),  32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors: push three, pop, push+pop, flush, empty corner.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].f, tbl[i].sv, tbl[i].sd, tbl[i].mr);
            chk($sformatf("vec%0d_count", i),  32'(count),        32'(tbl[i].ecount));
            chk($sformatf("vec%0d_mvalid", i), 32'(m_valid),      32'(tbl[i].emv));
            chk($sformatf("vec%0d_mdata", i),  32'(m_data),       32'(tbl[i].emd));
            chk($sformatf("vec%0d_sready", i), 32'(s_ready),      32'(tbl[i].esr));
            chk($sformatf("vec%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].eae));
        end

        // Fill to full, stall further pushes, pop-while-full, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        chk("full_count",  32'(count),       32'd16);
        chk("full_sready", 32'(s_ready),     32'd0);
        chk("full_afull",  32'(almost_full), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE, 1'b0);
        chk("full_stall_count", 32'(count), 32'd16);
        chk("full_head", 32'(m_data), 32'h00);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("full_pop_count",  32'(count),   32'd15);
        chk("full_pop_sready", 32'(s_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), 32'(m_data), 32'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("drain_count", 32'(count), 32'd0);

        // Streaming at constant occupancy 5 across pointer wrap.
        for (int k = 0; k < 45; k++) sent[k] = 8'(8'h80 + k);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, sent[k], 1'b0);
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("stream%0d_data", j), 32'(m_data), 32'(sent[j]));
            step(1'b0, 1'b1, sent[j + 5], 1'b1);
            chk($sformatf("stream%0d_count", j), 32'(count), 32'd5);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Flush at count 7 with a concurrent push that must be discarded.
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
        chk("pre_flush_count", 32'(count), 32'd7);
        step(1'b1, 1'b1, 8'hBB, 1'b0);
        chk("flush_count",  32'(count),   32'd0);
        chk("flush_mvalid", 32'(m_valid), 32'd0);
        chk("flush_sready", 32'(s_ready), 32'd1);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        chk("post_flush_head",  32'(m_data), 32'h77);
        chk("post_flush_count", 32'(count),  32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a burst at count 9.
        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 8'(8'h20 + k), 1'b0);
        chk("pre_rst_count", 32'(count), 32'd9);
        s_valid = 1'b1;
        s_data  = 8'h29;
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b1;
        model_q.delete();
        #1;
        chk("arst_count",  32'(count),        32'd0);
        chk("arst_sready", 32'(s_ready),      32'd1);
        chk("arst_mvalid", 32'(m_valid),      32'd0);
        chk("arst_mdata",  32'(m_data),       32'd0);
        chk("arst_afull",  32'(almost_full),  32'd0);
        chk("arst_aempty", 32'(almost_empty), 32'd1);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("post_rst_head",   32'(m_data),  32'hA5);
        chk("post_rst_mvalid", 32'(m_valid), 32'd1);
        chk("post_rst_count",  32'(count),   32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Randomised traffic; a rejected word is held until accepted.
        npush = 0;
        hold  = 1'b0;
        for (int cyc = 0; cyc < 70000 && npush < 10000; cyc++) begin
            logic          sv;
            logic [DW-1:0] sd;
            if (hold) begin
                sv = s_valid;
                sd = s_data;
            end else begin
                sv = 1'($urandom_range(0, 1));
                sd = 8'($urandom);
            end
            step(1'b0, sv, sd, 1'($urandom_range(0, 1)));
            if (last_push) npush++;
            hold = sv && !last_push;
        end
        chk("random_words_done", 32'(npush >= 10000), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
